// File: rtl/lpddr4_sched_pkg.sv
// Shared definitions for the LPDDR4 command scheduler: command encodings,
// FSM state encoding and the default timing constants.
package lpddr4_sched_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ACT  = 3'd1,
    OP_RD   = 3'd2,
    OP_WR   = 3'd3,
    OP_PRE  = 3'd4,
    OP_REF  = 3'd5,
    OP_PREA = 3'd6
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PRE      = 4'd1,
    ST_WAIT_RP  = 4'd2,
    ST_ACT      = 4'd3,
    ST_WAIT_RCD = 4'd4,
    ST_XFER     = 4'd5,
    ST_PREA     = 4'd6,
    ST_WAIT_RPA = 4'd7,
    ST_REF      = 4'd8,
    ST_WAIT_RFC = 4'd9
  } sched_state_e;

  localparam int DEF_T_RCD  = 8;
  localparam int DEF_T_RP   = 8;
  localparam int DEF_T_RFC  = 56;
  localparam int DEF_T_REFI = 3900;

  // Width of the shared wait counter and of the refresh interval counter.
  localparam int CNT_W = 16;

  function automatic cmd_op_e rw_op(input logic write);
    return write ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/lpddr4_bank_table.sv
// Per-bank open flag and open row, with a combinational hit/open lookup
// and registered set (ACT), clear (PRE) and clear-all (PREA/REF) updates.
module lpddr4_bank_table (
  input  logic        ck,
  input  logic        rst,
  input  logic [2:0]  lk_bank,
  input  logic [15:0] lk_row,
  output logic        lk_open,
  output logic        lk_hit,
  output logic        any_open,
  input  logic        set_en,
  input  logic [2:0]  set_bank,
  input  logic [15:0] set_row,
  input  logic        clr_en,
  input  logic [2:0]  clr_bank,
  input  logic        clr_all
);

  logic [7:0]  open_q;
  logic [15:0] row_q [8];

  assign lk_open  = open_q[lk_bank];
  assign lk_hit   = open_q[lk_bank] && (row_q[lk_bank] == lk_row);
  assign any_open = |open_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      open_q <= '0;
      for (int i = 0; i < 8; i++) row_q[i] <= '0;
    end else if (clr_all) begin
      open_q <= '0;
    end else begin
      if (clr_en) open_q[clr_bank] <= 1'b0;
      if (set_en) begin
        open_q[set_bank] <= 1'b1;
        row_q[set_bank]  <= set_row;
      end
    end
  end

endmodule

// File: rtl/lpddr4_cmd_sched.sv
// Two-requester LPDDR4 command scheduler with open-page policy and periodic
// refresh; define LPDDR4_SCHED_CLOSE_PAGE_EN for close-page operation.
module lpddr4_cmd_sched
  import lpddr4_sched_pkg::*;
#(
  parameter int T_RCD  = DEF_T_RCD,
  parameter int T_RP   = DEF_T_RP,
  parameter int T_RFC  = DEF_T_RFC,
  parameter int T_REFI = DEF_T_REFI
) (
  input  logic        ck,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [5:0]  req_bank,
  input  logic [31:0] req_row,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic [2:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic        cmd_id,
  output logic        ref_busy,
  output logic [3:0]  dbg_state
);

  // Handshake: req_ready is combinational from the FSM state and req_valid;
  // requester i transfers on the rising edge where req_valid[i] &&
  // req_ready[i]; at most one ready bit is high in any cycle.

  // Wait states are entered one cycle after their command, hence the -2.
  localparam logic [CNT_W-1:0] RCD_LOAD  = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] RP_LOAD   = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0] RFC_LOAD  = CNT_W'(T_RFC - 2);
  localparam logic [CNT_W-1:0] REFI_LOAD = CNT_W'(T_REFI - 1);

  sched_state_e     state;
  cmd_op_e          op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] refi_cnt;
  logic             ref_pending;
  logic             last_grant;
  logic             cap_write;
  logic [2:0]       cap_bank;
  logic [15:0]      cap_row;
  logic             cap_id;

  logic             gnt_id;
  logic             take;
  logic [2:0]       sel_bank;
  logic [15:0]      sel_row;
  logic             sel_write;
  logic             lk_open;
  logic             lk_hit;
  logic             any_open;

  always_comb begin
    gnt_id = 1'b0;
    if (&req_valid) gnt_id = ~last_grant;
    else            gnt_id = req_valid[1];
  end

  assign sel_bank  = gnt_id ? req_bank[5:3]  : req_bank[2:0];
  assign sel_row   = gnt_id ? req_row[31:16] : req_row[15:0];
  assign sel_write = req_write[gnt_id];

  assign take      = !rst && (state == ST_IDLE) && !ref_pending && (|req_valid);
  assign req_ready = take ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  assign cmd_op    = op_q;
  assign dbg_state = state;

  // The table follows the command bus, so banks change state on issue.
  lpddr4_bank_table u_bank_table (
    .ck       (ck),
    .rst      (rst),
    .lk_bank  (sel_bank),
    .lk_row   (sel_row),
    .lk_open  (lk_open),
    .lk_hit   (lk_hit),
    .any_open (any_open),
    .set_en   (cmd_valid && (op_q == OP_ACT)),
    .set_bank (cmd_bank),
    .set_row  (cmd_row),
    .clr_en   (cmd_valid && (op_q == OP_PRE)),
    .clr_bank (cmd_bank),
    .clr_all  (cmd_valid && ((op_q == OP_PREA) || (op_q == OP_REF)))
  );

  always_ff @(posedge ck) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_NOP;
      cmd_valid   <= 1'b0;
      cmd_bank    <= '0;
      cmd_row     <= '0;
      cmd_id      <= 1'b0;
      ref_busy    <= 1'b0;
      wait_cnt    <= '0;
      refi_cnt    <= REFI_LOAD;
      ref_pending <= 1'b0;
      last_grant  <= 1'b1;
      cap_write   <= 1'b0;
      cap_bank    <= '0;
      cap_row     <= '0;
      cap_id      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      op_q      <= OP_NOP;

      case (state)
        ST_IDLE: begin
          if (ref_pending) begin
            ref_busy  <= 1'b1;
            cmd_valid <= 1'b1;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_id    <= 1'b0;
            if (any_open) begin
              op_q  <= OP_PREA;
              state <= ST_PREA;
            end else begin
              op_q        <= OP_REF;
              state       <= ST_REF;
              ref_pending <= 1'b0;
            end
          end else if (|req_valid) begin
            last_grant <= gnt_id;
            cap_write  <= sel_write;
            cap_bank   <= sel_bank;
            cap_row    <= sel_row;
            cap_id     <= gnt_id;
            cmd_valid  <= 1'b1;
            cmd_bank   <= sel_bank;
            cmd_row    <= sel_row;
            cmd_id     <= gnt_id;
            if (lk_hit) begin
              op_q  <= rw_op(sel_write);
              state <= ST_XFER;
            end else if (lk_open) begin
              op_q  <= OP_PRE;
              state <= ST_PRE;
            end else begin
              op_q  <= OP_ACT;
              state <= ST_ACT;
            end
          end
        end
        ST_PRE: begin
          wait_cnt <= RP_LOAD;
          state    <= ST_WAIT_RP;
        end
        ST_WAIT_RP: begin
          if (wait_cnt == '0) begin
`ifdef LPDDR4_SCHED_CLOSE_PAGE_EN
            state <= ST_IDLE;
`else
            cmd_valid <= 1'b1;
            op_q      <= OP_ACT;
            cmd_bank  <= cap_bank;
            cmd_row   <= cap_row;
            cmd_id    <= cap_id;
            state     <= ST_ACT;
`endif
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ACT: begin
          wait_cnt <= RCD_LOAD;
          state    <= ST_WAIT_RCD;
        end
        ST_WAIT_RCD: begin
          if (wait_cnt == '0) begin
            cmd_valid <= 1'b1;
            op_q      <= rw_op(cap_write);
            cmd_bank  <= cap_bank;
            cmd_row   <= cap_row;
            cmd_id    <= cap_id;
            state     <= ST_XFER;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_XFER: begin
`ifdef LPDDR4_SCHED_CLOSE_PAGE_EN
          // Close the page right behind every transfer.
          cmd_valid <= 1'b1;
          op_q      <= OP_PRE;
          cmd_bank  <= cap_bank;
          cmd_row   <= cap_row;
          cmd_id    <= cap_id;
          state     <= ST_PRE;
`else
          state <= ST_IDLE;
`endif
        end
        ST_PREA: begin
          wait_cnt <= RP_LOAD;
          state    <= ST_WAIT_RPA;
        end
        ST_WAIT_RPA: begin
          if (wait_cnt == '0) begin
            cmd_valid   <= 1'b1;
            op_q        <= OP_REF;
            cmd_bank    <= '0;
            cmd_row     <= '0;
            cmd_id      <= 1'b0;
            ref_pending <= 1'b0;
            state       <= ST_REF;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_REF: begin
          wait_cnt <= RFC_LOAD;
          state    <= ST_WAIT_RFC;
        end
        ST_WAIT_RFC: begin
          if (wait_cnt == '0) begin
            ref_busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the FSM so a fresh expiry wins over a same-edge clear.
      if (refi_cnt == '0) begin
        refi_cnt    <= REFI_LOAD;
        ref_pending <= 1'b1;
      end else begin
        refi_cnt <= refi_cnt - 1'b1;
      end
    end
  end

endmodule
